// File: rtl/mips_decls_p.sv
// mips_decls_p: opcodes, function codes, FSM states and datapath select encodings
// shared by the multicycle MIPS main decoder and its wait counter.
package mips_decls_p;

    typedef logic [5:0] opcode_t;
    typedef logic [5:0] funct_t;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        RTEX   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11,
        JAL    = 4'd12,
        JR     = 4'd13,
        ERR    = 4'd14
    } statetype_t;

    localparam opcode_t OP_RTYPE = 6'b000000;
    localparam opcode_t OP_LW    = 6'b100011;
    localparam opcode_t OP_SW    = 6'b101011;
    localparam opcode_t OP_BEQ   = 6'b000100;
    localparam opcode_t OP_BNE   = 6'b000101;
    localparam opcode_t OP_ADDI  = 6'b001000;
    localparam opcode_t OP_J     = 6'b000010;
    localparam opcode_t OP_JAL   = 6'b000011;

    localparam funct_t F_JR = 6'b001000;

    localparam logic [1:0] RD_RT  = 2'b00;
    localparam logic [1:0] RD_RD  = 2'b01;
    localparam logic [1:0] RD_R31 = 2'b10;

    localparam logic [1:0] MT_ALUOUT = 2'b00;
    localparam logic [1:0] MT_MEM    = 2'b01;
    localparam logic [1:0] MT_PC     = 2'b10;

    localparam logic [1:0] SB_RT    = 2'b00;
    localparam logic [1:0] SB_FOUR  = 2'b01;
    localparam logic [1:0] SB_IMM   = 2'b10;
    localparam logic [1:0] SB_IMMSH = 2'b11;

    localparam logic [1:0] PS_ALU    = 2'b00;
    localparam logic [1:0] PS_ALUOUT = 2'b01;
    localparam logic [1:0] PS_JUMP   = 2'b10;
    localparam logic [1:0] PS_RS     = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // States that wait on the memory handshake and are bounded by the timeout.
    function automatic logic is_mem_state(statetype_t s);
        return s inside {FETCH, MEMRD, MEMWR};
    endfunction

endpackage

// File: rtl/mcyc_waitctr.sv
// mcyc_waitctr: counts consecutive mem_ready-low cycles in a memory state and
// flags the cycle in which the wait budget MAX_WAIT is exhausted.
module mcyc_waitctr #(
    parameter int MAX_WAIT = 4,
    parameter int WCNT_W   = $clog2(MAX_WAIT + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              inc,
    output logic [WCNT_W-1:0] cnt,
    output logic              timeout
);

    localparam logic [WCNT_W-1:0] LIMIT = WCNT_W'(MAX_WAIT);

    logic [WCNT_W-1:0] cnt_d, cnt_q;

    assign timeout = inc && (cnt_q == LIMIT);
    assign cnt     = cnt_q;

    always_comb cnt_d = clr ? '0 : (inc && !timeout) ? cnt_q + WCNT_W'(1) : cnt_q;

    always_ff @(posedge clk)
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;

endmodule

// File: rtl/mcyc_maindec.sv
// mcyc_maindec: multicycle MIPS main decoder FSM with memory wait timeout.
// Define MCYC_BNE_EN to decode bne (opcode 000101) as an inverted-condition branch.
module mcyc_maindec
    import mips_decls_p::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int WCNT_W   = $clog2(MAX_WAIT + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       iord,
    output logic       regwrite,
    output logic       alusrca,
    output logic       pcen,
    output logic [1:0] regdst,
    output logic [1:0] memtoreg,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic [3:0] state_o,
    output logic       error
);

    statetype_t state_q, state_d, dec_next;
    logic mr, mw, iw, rw, pcwrite, branch, taken;
    logic timeout, wait_clr, wait_inc;
    logic [WCNT_W-1:0] wait_cnt_unused;

    assign wait_inc = is_mem_state(state_q) && !mem_ready;
    assign wait_clr = is_mem_state(state_d) && (state_d != state_q);

    mcyc_waitctr #(
        .MAX_WAIT(MAX_WAIT),
        .WCNT_W  (WCNT_W)
    ) u_waitctr (
        .clk    (clk),
        .reset  (reset),
        .clr    (wait_clr),
        .inc    (wait_inc),
        .cnt    (wait_cnt_unused),
        .timeout(timeout)
    );

`ifdef MCYC_BNE_EN
    assign taken = (opcode == OP_BNE) ? ~zero : zero;
`else
    assign taken = zero;
`endif

    always_comb begin
        dec_next = ERR;
        case (opcode)
            OP_LW, OP_SW: dec_next = MEMADR;
            OP_RTYPE:     dec_next = (funct == F_JR) ? JR : RTEX;
            OP_BEQ:       dec_next = BRANCH;
`ifdef MCYC_BNE_EN
            OP_BNE:       dec_next = BRANCH;
`endif
            OP_ADDI:      dec_next = ADDIEX;
            OP_J:         dec_next = JUMP;
            OP_JAL:       dec_next = JAL;
            default:      dec_next = ERR;
        endcase
    end

    always_ff @(posedge clk)
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;

    always_comb begin
        state_d  = state_q;
        mr       = 1'b0;
        mw       = 1'b0;
        iw       = 1'b0;
        rw       = 1'b0;
        iord     = 1'b0;
        alusrca  = 1'b0;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        regdst   = RD_RT;
        memtoreg = MT_ALUOUT;
        alusrcb  = SB_RT;
        pcsrc    = PS_ALU;
        aluop    = ALUOP_ADD;
        case (state_q)
            FETCH: begin
                mr      = 1'b1;
                alusrcb = SB_FOUR;
                iw      = mem_ready;
                pcwrite = mem_ready;
                state_d = mem_ready ? DECODE : timeout ? ERR : FETCH;
            end
            DECODE: begin
                alusrcb = SB_IMMSH;
                state_d = dec_next;
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SB_IMM;
                state_d = (opcode == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                mr      = 1'b1;
                iord    = 1'b1;
                state_d = mem_ready ? MEMWB : timeout ? ERR : MEMRD;
            end
            MEMWB: begin
                rw       = 1'b1;
                memtoreg = MT_MEM;
                state_d  = FETCH;
            end
            MEMWR: begin
                mw      = 1'b1;
                iord    = 1'b1;
                state_d = mem_ready ? FETCH : timeout ? ERR : MEMWR;
            end
            RTEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
                state_d = ALUWB;
            end
            ALUWB: begin
                rw      = 1'b1;
                regdst  = RD_RD;
                state_d = FETCH;
            end
            BRANCH: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = PS_ALUOUT;
                branch  = 1'b1;
                state_d = FETCH;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = SB_IMM;
                state_d = ADDIWB;
            end
            ADDIWB: begin
                rw      = 1'b1;
                state_d = FETCH;
            end
            JUMP: begin
                pcwrite = 1'b1;
                pcsrc   = PS_JUMP;
                state_d = FETCH;
            end
            JAL: begin
                pcwrite  = 1'b1;
                pcsrc    = PS_JUMP;
                rw       = 1'b1;
                regdst   = RD_R31;
                memtoreg = MT_PC;
                state_d  = FETCH;
            end
            JR: begin
                pcwrite = 1'b1;
                pcsrc   = PS_RS;
                state_d = FETCH;
            end
            default: state_d = ERR;
        endcase
    end

    // The timeout cycle issues no memory access; reset suppresses every write.
    assign memread  = mr & ~timeout;
    assign memwrite = mw & ~timeout & ~reset;
    assign irwrite  = iw & ~reset;
    assign regwrite = rw & ~reset;
    assign pcen     = (pcwrite | (branch & taken)) & ~reset;
    assign state_o  = state_q;
    assign error    = (state_q == ERR);

endmodule

// File: tb/tb_mcyc_maindec.sv
// tb_mcyc_maindec: directed sequences, a vector table and randomized instructions
// checked against an instruction-level latency/strobe-count model.
module tb_mcyc_maindec;
    import mips_decls_p::*;

    localparam int MAX_WAIT = 4;

    logic       clk = 1'b0, reset = 1'b1;
    logic [5:0] opcode = '0, funct = '0;
    logic       zero = 1'b0, mem_ready = 1'b0;
    logic       memread, memwrite, irwrite, iord, regwrite, alusrca, pcen, error;
    logic [1:0] regdst, memtoreg, alusrcb, pcsrc, aluop;
    logic [3:0] state_o;

    mcyc_maindec #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
        .iord(iord), .regwrite(regwrite), .alusrca(alusrca), .pcen(pcen), .regdst(regdst),
        .memtoreg(memtoreg), .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop),
        .state_o(state_o), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int len;
        int err_at;
        int n_ir, n_rw, n_mw, n_pc;
        logic [1:0] rd, mt, pcs;
    } exp_t;

    typedef struct {
        logic [5:0] op, fn;
        logic z;
        int wf, wm;
        exp_t e;
    } vec_t;

    int n_vec = 0, n_bad = 0;
    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [5:0] op, fn, input logic z, input int wf, wm,
                                len, err_at, ir, rw, mw, pc, input logic [1:0] rd, mt, pcs);
        vec_t v;
        v.op = op; v.fn = fn; v.z = z; v.wf = wf; v.wm = wm;
        v.e.len = len; v.e.err_at = err_at; v.e.n_ir = ir; v.e.n_rw = rw;
        v.e.n_mw = mw; v.e.n_pc = pc; v.e.rd = rd; v.e.mt = mt; v.e.pcs = pcs;
        return v;
    endfunction

    // Instruction-level model: wf/wm are mem_ready-low cycles before completion in
    // FETCH and in the data-memory state; a wait above MAX_WAIT means timeout.
    function automatic exp_t model(input logic [5:0] op, fn, input logic z, input int wf, wm);
        exp_t e;
        int f;
        bit bne_ok;
        bit is_sw;
        e.len = 0; e.err_at = -1; e.n_ir = 0; e.n_rw = 0; e.n_mw = 0; e.n_pc = 0;
        e.rd = 2'b00; e.mt = 2'b00; e.pcs = 2'b00;
        f = wf + 1;
        bne_ok = 1'b0;
`ifdef MCYC_BNE_EN
        bne_ok = 1'b1;
`endif
        if (wf > MAX_WAIT) begin
            e.err_at = MAX_WAIT + 1;
            return e;
        end
        e.n_ir = 1;
        e.n_pc = 1;
        is_sw = (op == 6'b101011);
        if (op == 6'b100011 || is_sw) begin
            if (wm > MAX_WAIT) begin
                e.err_at = f + 2 + MAX_WAIT + 1;
                e.n_mw = is_sw ? MAX_WAIT : 0;
            end else begin
                e.len  = f + 3 + wm + (is_sw ? 0 : 1);
                e.n_mw = is_sw ? wm + 1 : 0;
                e.n_rw = is_sw ? 0 : 1;
                e.mt   = 2'b01;
            end
        end else if (op == 6'b000000 && fn == 6'b001000) begin
            e.len = f + 2; e.n_pc = 2; e.pcs = 2'b11;
        end else if (op == 6'b000000) begin
            e.len = f + 3; e.n_rw = 1; e.rd = 2'b01;
        end else if (op == 6'b001000) begin
            e.len = f + 3; e.n_rw = 1;
        end else if (op == 6'b000100 || (op == 6'b000101 && bne_ok)) begin
            e.len = f + 2; e.pcs = 2'b01;
            e.n_pc = 1 + (((op == 6'b000101) ? !z : z) ? 1 : 0);
        end else if (op == 6'b000010) begin
            e.len = f + 2; e.n_pc = 2; e.pcs = 2'b10;
        end else if (op == 6'b000011) begin
            e.len = f + 2; e.n_pc = 2; e.n_rw = 1; e.rd = 2'b10; e.mt = 2'b10; e.pcs = 2'b10;
        end else begin
            e.err_at = f + 1;
        end
        return e;
    endfunction

    task automatic step(input logic [5:0] op, fn, input logic z, rdy, rst);
        @(negedge clk);
        opcode = op; funct = fn; zero = z; mem_ready = rdy; reset = rst;
        #1;
    endtask

    // Runs one instruction starting in a fresh FETCH; mem_ready follows the wait
    // schedule, other inputs are randomized where the decoder must ignore them.
    task automatic run(input string tag, input vec_t v);
        int bound, f, ir, rw, mw, pc, first_err;
        bit is_mem;
        f = v.wf + 1;
        bound = (v.e.err_at >= 0) ? v.e.err_at + 3 : v.e.len;
        is_mem = (v.op == 6'b100011 || v.op == 6'b101011);
        ir = 0; rw = 0; mw = 0; pc = 0; first_err = -1;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            reset  = 1'b0;
            zero   = v.z;
            opcode = (k < f) ? 6'($urandom) : v.op;
            funct  = (k < f) ? 6'($urandom) : v.fn;
            if (k < f) mem_ready = (k == f - 1) && (v.wf <= MAX_WAIT);
            else if (is_mem && k >= f + 2) mem_ready = (k - f - 2) >= v.wm;
            else mem_ready = 1'($urandom);
            #1;
            if (k == 0) begin
                chk({tag, " start state"}, state_o, FETCH);
                chk({tag, " start error"}, error, 0);
            end
            if (irwrite) ir++;
            if (memwrite) mw++;
            if (regwrite) begin
                rw++;
                chk({tag, " regdst"}, regdst, v.e.rd);
                chk({tag, " memtoreg"}, memtoreg, v.e.mt);
            end
            if (pcen) begin
                pc++;
                chk({tag, " pcsrc"}, pcsrc, (k == f - 1) ? 0 : v.e.pcs);
            end
            if (error && first_err < 0) first_err = k;
        end
        chk({tag, " irwrite cycles"}, ir, v.e.n_ir);
        chk({tag, " regwrite cycles"}, rw, v.e.n_rw);
        chk({tag, " memwrite cycles"}, mw, v.e.n_mw);
        chk({tag, " pcen cycles"}, pc, v.e.n_pc);
        chk({tag, " error cycle"}, first_err, v.e.err_at);
        if (v.e.err_at >= 0) begin
            chk({tag, " error sticky"}, error, 1);
            step(6'($urandom), 6'($urandom), 1'b1, 1'b1, 1'b1);
            chk({tag, " reset pcen"}, pcen, 0);
        end
    endtask

    statetype_t lw_st[5] = '{FETCH, DECODE, MEMADR, MEMRD, MEMWB};
    logic [5:0] pool[10] = '{6'b100011, 6'b101011, 6'b000000, 6'b000000, 6'b001000,
                             6'b000100, 6'b000101, 6'b000010, 6'b000011, 6'b111111};

    initial begin
        int cnt;
        vec_t v;
        // Reset: FETCH with mem_ready high would strobe, but reset gates it.
        step(6'b100011, 6'b0, 1'b0, 1'b1, 1'b1);
        step(6'b100011, 6'b0, 1'b0, 1'b1, 1'b1);
        chk("reset state", state_o, FETCH);
        chk("reset error", error, 0);
        chk("reset irwrite gated", irwrite, 0);
        chk("reset pcen gated", pcen, 0);

        // lw, mem_ready high: five states, single write-back in the last.
        for (int k = 0; k < 5; k++) begin
            step(6'b100011, 6'b0, 1'b0, 1'b1, 1'b0);
            chk($sformatf("lw state c%0d", k + 1), state_o, lw_st[k]);
            chk($sformatf("lw regwrite c%0d", k + 1), regwrite, k == 4);
            chk($sformatf("lw memread c%0d", k + 1), memread, k == 0 || k == 3);
            if (k == 4) chk("lw memtoreg", memtoreg, 2'b01);
        end

        // R-type reset in ALUWB: write-back suppressed, FETCH afterwards.
        for (int k = 0; k < 3; k++) step(6'b000000, 6'b100000, 1'b0, 1'b1, 1'b0);
        step(6'b000000, 6'b100000, 1'b0, 1'b1, 1'b1);
        chk("rst in ALUWB state", state_o, ALUWB);
        chk("rst in ALUWB regwrite", regwrite, 0);
        step(6'b000000, 6'b100000, 1'b0, 1'b1, 1'b1);
        chk("after rst state", state_o, FETCH);

        // FETCH timeout, sticky error, recovery by a one-cycle reset.
        cnt = 0;
        for (int k = 0; k < 20 && !error; k++) begin
            step(6'($urandom), 6'($urandom), 1'b0, 1'b0, 1'b0);
            if (state_o == FETCH) cnt++;
        end
        chk("timeout fetch cycles", cnt, MAX_WAIT + 1);
        chk("timeout state", state_o, ERR);
        for (int k = 0; k < 3; k++) begin
            step(6'b100011, 6'b0, 1'b1, 1'b1, 1'b0);
            chk("error sticky", error, 1);
            chk("ERR pcen", pcen, 0);
        end
        step(6'b0, 6'b0, 1'b0, 1'b0, 1'b1);
        step(6'b0, 6'b0, 1'b0, 1'b0, 1'b0);
        chk("recover state", state_o, FETCH);
        chk("recover error", error, 0);
        step(6'b0, 6'b0, 1'b0, 1'b0, 1'b1);

        //            op         fn         z     wf wm len err ir rw mw pc rd     mt     pcs
        tbl.push_back(mk(6'b100011, 6'b000000, 1'b0, 0, 0, 5, -1, 1, 1, 0, 1, 2'b00, 2'b01, 2'b00));
        tbl.push_back(mk(6'b101011, 6'b000000, 1'b0, 0, 2, 6, -1, 1, 0, 3, 1, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(6'b000000, 6'b100000, 1'b0, 0, 0, 4, -1, 1, 1, 0, 1, 2'b01, 2'b00, 2'b00));
        tbl.push_back(mk(6'b001000, 6'b000000, 1'b0, 1, 0, 5, -1, 1, 1, 0, 1, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(6'b000100, 6'b000000, 1'b1, 0, 0, 3, -1, 1, 0, 0, 2, 2'b00, 2'b00, 2'b01));
        tbl.push_back(mk(6'b000100, 6'b000000, 1'b0, 0, 0, 3, -1, 1, 0, 0, 1, 2'b00, 2'b00, 2'b01));
        tbl.push_back(mk(6'b000010, 6'b000000, 1'b0, 0, 0, 3, -1, 1, 0, 0, 2, 2'b00, 2'b00, 2'b10));
        tbl.push_back(mk(6'b000011, 6'b000000, 1'b0, 0, 0, 3, -1, 1, 1, 0, 2, 2'b10, 2'b10, 2'b10));
        tbl.push_back(mk(6'b000000, 6'b001000, 1'b0, 0, 0, 3, -1, 1, 0, 0, 2, 2'b00, 2'b00, 2'b11));
        tbl.push_back(mk(6'b100011, 6'b000000, 1'b0, 3, 4, 12, -1, 1, 1, 0, 1, 2'b00, 2'b01, 2'b00));
        tbl.push_back(mk(6'b111111, 6'b000000, 1'b0, 0, 0, 0, 2, 1, 0, 0, 1, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(6'b101011, 6'b000000, 1'b0, 0, 5, 0, 8, 1, 0, 4, 1, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(6'b100011, 6'b000000, 1'b0, 0, 5, 0, 8, 1, 0, 0, 1, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(6'b100011, 6'b000000, 1'b0, 5, 0, 0, 5, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
`ifdef MCYC_BNE_EN
        tbl.push_back(mk(6'b000101, 6'b000000, 1'b0, 0, 0, 3, -1, 1, 0, 0, 2, 2'b00, 2'b00, 2'b01));
        tbl.push_back(mk(6'b000101, 6'b000000, 1'b1, 0, 0, 3, -1, 1, 0, 0, 1, 2'b00, 2'b00, 2'b01));
`else
        tbl.push_back(mk(6'b000101, 6'b000000, 1'b0, 0, 0, 0, 2, 1, 0, 0, 1, 2'b00, 2'b00, 2'b00));
`endif
        foreach (tbl[i]) run($sformatf("tbl%0d", i), tbl[i]);

        for (int i = 0; i < 150; i++) begin
            v.op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : pool[$urandom_range(0, 9)];
            v.fn = ($urandom_range(0, 3) == 0) ? 6'b001000 : 6'($urandom);
            v.z  = 1'($urandom);
            v.wf = ($urandom_range(0, 11) == 0) ? MAX_WAIT + 1 : int'($urandom_range(0, MAX_WAIT));
            v.wm = ($urandom_range(0, 11) == 0) ? MAX_WAIT + 1 : int'($urandom_range(0, MAX_WAIT));
            v.e  = model(v.op, v.fn, v.z, v.wf, v.wm);
            run($sformatf("rnd%0d op=%b fn=%b", i, v.op, v.fn), v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
